// File: rtl/key_bcd_counter_pkg.sv
// Shared definitions for the two-button BCD counter: debounce FSM encoding,
// BCD digit limits and per-nibble step helpers.
package key_bcd_counter_pkg;

    localparam logic [1:0] ST_REL   = 2'd0;
    localparam logic [1:0] ST_P_CHK = 2'd1;
    localparam logic [1:0] ST_PRS   = 2'd2;
    localparam logic [1:0] ST_R_CHK = 2'd3;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam int         COUNT_W = 8;

    // Returns {wrap, tens, units} after a one-step BCD increment.
    function automatic logic [8:0] bcd_step_up(input logic [7:0] value);
        logic [3:0] tens;
        logic [3:0] units;
        logic       wrap;
        tens  = value[7:4];
        units = value[3:0];
        wrap  = 1'b0;
        if (units == BCD_MAX) begin
            units = 4'd0;
            if (tens == BCD_MAX) begin
                tens = 4'd0;
                wrap = 1'b1;
            end else begin
                tens = tens + 4'd1;
            end
        end else begin
            units = units + 4'd1;
        end
        return {wrap, tens, units};
    endfunction

    // Returns {wrap, tens, units} after a one-step BCD decrement.
    function automatic logic [8:0] bcd_step_down(input logic [7:0] value);
        logic [3:0] tens;
        logic [3:0] units;
        logic       wrap;
        tens  = value[7:4];
        units = value[3:0];
        wrap  = 1'b0;
        if (units == 4'd0) begin
            units = BCD_MAX;
            if (tens == 4'd0) begin
                tens = BCD_MAX;
                wrap = 1'b1;
            end else begin
                tens = tens - 4'd1;
            end
        end else begin
            units = units - 4'd1;
        end
        return {wrap, tens, units};
    endfunction

endpackage

// File: rtl/key_bcd_counter_key_debounce.sv
// Two-flop synchroniser plus press/release qualification FSM for one raw key.
// Emits a single-cycle press pulse per qualified press; releases are silent.
module key_debounce
    import key_bcd_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_50M,
    input  logic rst_button,
    input  logic key,
    output logic press,
    output logic held
);

    localparam logic [23:0] CNT_LAST = 24'(DEBOUNCE_CYCLES - 1);

    logic [1:0]  sync_r;
    logic [1:0]  state_r;
    logic [1:0]  state_s;
    logic [23:0] cnt_r;
    logic [23:0] cnt_s;
    logic        press_r;
    logic        press_s;
    logic        held_r;
    logic        held_s;
    logic        sync_s;

    assign sync_s = sync_r[1];

    // Bring the raw key into the clock domain.
    always_ff @(posedge clk_50M or negedge rst_button) begin
        if (!rst_button) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], key};
        end
    end

    // Next-state logic; cnt only advances while qualifying, so it stops at the compare value.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        press_s = 1'b0;
        case (state_r)
            ST_REL: begin
                if (sync_s) begin
                    state_s = ST_P_CHK;
                    cnt_s   = 24'd0;
                end else begin
                    state_s = ST_REL;
                end
            end
            ST_P_CHK: begin
                if (!sync_s) begin
                    state_s = ST_REL;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_PRS;
                    press_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + 24'd1;
                end
            end
            ST_PRS: begin
                if (!sync_s) begin
                    state_s = ST_R_CHK;
                    cnt_s   = 24'd0;
                end else begin
                    state_s = ST_PRS;
                end
            end
            ST_R_CHK: begin
                if (sync_s) begin
                    state_s = ST_PRS;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_REL;
                end else begin
                    cnt_s = cnt_r + 24'd1;
                end
            end
            default: begin
                state_s = ST_REL;
                cnt_s   = 24'd0;
            end
        endcase
        held_s = (state_s == ST_PRS) || (state_s == ST_R_CHK);
    end

    // FSM state, counter and registered outputs.
    always_ff @(posedge clk_50M or negedge rst_button) begin
        if (!rst_button) begin
            state_r <= ST_REL;
            cnt_r   <= 24'd0;
            press_r <= 1'b0;
            held_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            press_r <= press_s;
            held_r  <= held_s;
        end
    end

    assign press = press_r;
    assign held  = held_r;

endmodule

// File: rtl/key_bcd_counter.sv
// Two-digit BCD up/down counter driven by debounced increment and decrement keys,
// feeding the dual seven-segment display scanner.
module key_bcd_counter
    import key_bcd_counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic               clk_50M,
    input  logic               rst_button,
    input  logic               key_inc,
    input  logic               key_dec,
    input  logic               clr,
    output logic [COUNT_W-1:0] count_bcd,
    output logic               wrap_pulse,
    output logic [1:0]         key_held
);

    logic               inc_press_s;
    logic               dec_press_s;
    logic               inc_held_s;
    logic               dec_held_s;
    logic [COUNT_W-1:0] count_r;
    logic [COUNT_W-1:0] count_s;
    logic               wrap_r;
    logic               wrap_s;
    logic [8:0]         step_up_s;
    logic [8:0]         step_down_s;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_debounce (
        .clk_50M    (clk_50M),
        .rst_button (rst_button),
        .key        (key_inc),
        .press      (inc_press_s),
        .held       (inc_held_s)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec_debounce (
        .clk_50M    (clk_50M),
        .rst_button (rst_button),
        .key        (key_dec),
        .press      (dec_press_s),
        .held       (dec_held_s)
    );

    assign step_up_s   = bcd_step_up(count_r);
    assign step_down_s = bcd_step_down(count_r);

    // Clear wins over presses; opposing presses in one cycle cancel.
    always_comb begin
        count_s = count_r;
        wrap_s  = 1'b0;
        if (clr) begin
            count_s = 8'h00;
        end else if (inc_press_s && dec_press_s) begin
            count_s = count_r;
        end else if (inc_press_s) begin
            count_s = step_up_s[7:0];
            wrap_s  = step_up_s[8];
        end else if (dec_press_s) begin
            count_s = step_down_s[7:0];
            wrap_s  = step_down_s[8];
        end else begin
            count_s = count_r;
        end
    end

    // Count and wrap registers.
    always_ff @(posedge clk_50M or negedge rst_button) begin
        if (!rst_button) begin
            count_r <= 8'h00;
            wrap_r  <= 1'b0;
        end else begin
            count_r <= count_s;
            wrap_r  <= wrap_s;
        end
    end

    assign count_bcd  = count_r;
    assign wrap_pulse = wrap_r;
    assign key_held   = {dec_held_s, inc_held_s};

endmodule

// File: doc/key_bcd_counter.md
# key_bcd_counter

Debounced two-button BCD counter that produces the 8-bit two-digit value shown on the board's dual seven-segment display. It sits directly upstream of the display scanner, and its count_bcd output drives the scanner's 8-bit digit input in place of the DIP switches. High nibble is tens and low nibble is units. Both buttons are bounced, asynchronous board inputs; this block synchronises them, debounces them and turns each clean press into exactly one count step.

## Interface
- DEBOUNCE_CYCLES, default 1000000: cycles a key level must persist before it is accepted (20 ms at 50 MHz). Legal range is 2 to 2^24-1.
- clk_50M  input  1  board 50 MHz clock. This is the only clock.
- rst_button  input  1  reset. Asynchronous assert, active-low: 0 means reset.
- key_inc  input  1  increment button, raw and asynchronous. 1 = pressed.
- key_dec  input  1  decrement button, raw and asynchronous. 1 = pressed.
- clr  input  1  synchronous clear, active-high, already clean.
- count_bcd  output  8  [7:4] tens, [3:0] units. Each nibble is always in 0–9.
- wrap_pulse  output  1  one-cycle pulse on 99→00 (increment) or 00→99 (decrement).
- key_held  output  2  debounced level {dec, inc}.

## Operation
- Each key passes through a 2-flop synchroniser. The second flop output (sync) feeds that key's debounce FSM. There are two identical FSMs, one per key.
- FSM states and transitions:
  - REL: if sync=1, go to P_CHK and set cnt=0.
  - P_CHK: if sync=0, return to REL. Else if cnt==DEBOUNCE_CYCLES-1, go to PRS and emit a press pulse. Else cnt+1.
  - PRS: if sync=0, go to R_CHK and set cnt=0.
  - R_CHK: if sync=1, return to PRS. Else if cnt==DEBOUNCE_CYCLES-1, go to REL. Else cnt+1.
- key_held bit is 1 in PRS and R_CHK.
- A release produces no event. A key held indefinitely produces exactly one press and no auto-repeat.
- Counter update priority, one step per cycle, all registered:
  1. clr=1 sets count_bcd to 8'h00. Press pulses in the same cycle are discarded.
  2. An inc press and a dec press in the same cycle cancel, leaving count unchanged.
  3. inc press adds 1 to units. Units 9 wraps to 0 and carries into tens. 99 becomes 00 and fires wrap_pulse.
  4. dec press subtracts 1 from units. Units 0 wraps to 9 and borrows from tens. 00 becomes 99 and fires wrap_pulse.
- Arithmetic is per nibble in BCD. Binary add or subtract followed by conversion is not permitted. Illegal nibble values (A–F) are unreachable.

## Timing
- Reset (rst_button=0) asynchronously clears:
  - all synchroniser flops to 0
  - both FSMs to REL with cnt=0
  - count_bcd=8'h00, wrap_pulse=0, key_held=2'b00
- Reset deasserting mid-press re-qualifies the held key from scratch. A key already held at deassertion yields one press after full qualification.
- Press latency, with edge 1 defined as the first clk_50M rising edge at which the key is sampled 1:
  - edge 3: the FSM enters P_CHK.
  - edge DEBOUNCE_CYCLES+3: the FSM enters PRS and the press pulse registers.
  - edge DEBOUNCE_CYCLES+4: count_bcd updates.
- wrap_pulse is high for exactly the cycle following that count update edge.
- Any sync=0 sample during P_CHK aborts qualification, so a shorter glitch produces no event. Any sync=1 sample during R_CHK returns the FSM to PRS with no new event.
- The cnt register is 24 bits wide. It never wraps, because it saturates at compare.

## Structure
- The shared display package holds:
  - the FSM state encoding (REL, P_CHK, PRS, R_CHK as 2-bit localparams)
  - the BCD digit max constant (4'd9)
  - the count width (8)
- Sub-module key_debounce contains the synchroniser, the FSM and cnt. It takes DEBOUNCE_CYCLES and outputs press and held. The top instantiates it twice.
- The top holds the BCD counter and the wrap logic.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset: hold rst_button=0 with keys toggling → count_bcd=00, key_held=00, wrap_pulse=0 throughout. Release reset with keys at 0 → state stays the same.
- Clean press: key_inc goes high and is held 20 cycles. count_bcd goes 00→01 at edge 8, exactly once. key_held[0]=1 from edge 7.
- Bounce: key_inc pulses high 3 cycles, low 1, high 3, low → no count change. A following 10-cycle press → count +1.
- Wrap: preload to 09 by presses, then one inc → 10. Preload to 99, then inc → 00 with wrap_pulse for 1 cycle. Then dec → 99 with wrap_pulse again.
- Simultaneous: key_inc and key_dec rise on the same cycle from 42 → count stays 42. clr asserted in the press-pulse cycle → 00.
- Async reset mid-qualification: assert rst_button low in P_CHK → immediate clear. Release with key still high → one press 7 edges later.
